// File: rtl/opcode_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : opcode_sequencer
//  Description : Accepts 4-bit opcodes over a valid/ready handshake and issues
//                the matching 12-bit datapath control word for one cycle, or
//                for N cycles for repeatable opcodes. Supports abort, reports
//                illegal opcodes and counts down the remaining issue cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module opcode_sequencer #(
   parameter int CNT_W = 10
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             op_valid_i,
   output logic             op_ready_o,
   input  logic [3:0]       op_i,
   input  logic [CNT_W-1:0] arg_i,
   input  logic             abort_i,
   output logic [2:0]       primary_register_control_o,
   output logic [1:0]       secondary_register_control_o,
   output logic [1:0]       bit_counter_register_control_o,
   output logic             comparator_register_control_o,
   output logic             comparator_demux_control_o,
   output logic             passthrough_demux_control_o,
   output logic [1:0]       output_demux_control_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             illegal_o,
   output logic [CNT_W-1:0] remaining_o
);

   localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] c_ZERO = '0;
   localparam logic [11:0]      c_HOLD = 12'h000;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_ISSUE = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [11:0]      r_word;
   logic [11:0]      w_word_nxt;
   logic [CNT_W-1:0] r_rem;
   logic [CNT_W-1:0] w_rem_nxt;
   logic             r_illegal;
   logic             w_illegal_nxt;

   logic [11:0]      w_op_word;
   logic             w_repeatable;
   logic             w_is_illegal;
   logic [CNT_W-1:0] w_load_rem;
   logic             w_last;
   logic             w_ready;
   logic             w_accept;

   // The current issue cycle is the final one when nothing remains after it.
   assign w_last   = (r_rem == c_ZERO);
   assign w_ready  = !rst_i && !abort_i && ((r_state == ST_IDLE) || w_last);
   assign w_accept = op_valid_i && w_ready;

   // Opcode decode: control word, repeatability and legality.
   always_comb begin
      w_op_word    = c_HOLD;
      w_repeatable = 1'b0;
      w_is_illegal = 1'b0;
      case (op_i)
         4'h0: w_op_word = 12'hE00;
         4'h1: w_op_word = 12'hC00;
         4'h2: begin w_op_word = 12'h600; w_repeatable = 1'b1; end
         4'h3: begin w_op_word = 12'h220; w_repeatable = 1'b1; end
         4'h4: w_op_word = 12'h180;
         4'h5: w_op_word = 12'h100;
         4'h6: begin w_op_word = 12'h080; w_repeatable = 1'b1; end
         4'h7: w_op_word = 12'h002;
         4'h8: w_op_word = 12'h003;
         4'h9: w_op_word = 12'h040;
         4'hA: w_op_word = 12'h010;
         4'hB: w_op_word = 12'h001;
         4'hC: w_op_word = 12'h005;
         4'hD: w_is_illegal = 1'b1;
         4'hE: w_is_illegal = 1'b1;
         default: w_op_word = c_HOLD;
      endcase
   end

   // Issue count after the first cycle: N-1, with an argument of zero meaning N=1.
   always_comb begin
      w_load_rem = c_ZERO;
      if (w_repeatable && (arg_i != c_ZERO)) begin
         w_load_rem = arg_i - c_ONE;
      end
   end

   // Next-state logic: abort wins over accept, accept wins over continuing.
   always_comb begin
      w_state_nxt   = ST_IDLE;
      w_word_nxt    = c_HOLD;
      w_rem_nxt     = c_ZERO;
      w_illegal_nxt = 1'b0;
      if (abort_i) begin
         w_state_nxt = ST_IDLE;
      end else if (w_accept) begin
         w_state_nxt   = ST_ISSUE;
         w_word_nxt    = w_op_word;
         w_rem_nxt     = w_load_rem;
         w_illegal_nxt = w_is_illegal;
      end else if ((r_state == ST_ISSUE) && !w_last) begin
         w_state_nxt = ST_ISSUE;
         w_word_nxt  = r_word;
         w_rem_nxt   = r_rem - c_ONE;
      end
   end

   // State, control word and counter registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state   <= ST_IDLE;
         r_word    <= c_HOLD;
         r_rem     <= c_ZERO;
         r_illegal <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_word    <= w_word_nxt;
         r_rem     <= w_rem_nxt;
         r_illegal <= w_illegal_nxt;
      end
   end

   assign op_ready_o                     = w_ready;
   assign primary_register_control_o     = r_word[11:9];
   assign secondary_register_control_o   = r_word[8:7];
   assign bit_counter_register_control_o = r_word[6:5];
   assign comparator_register_control_o  = r_word[4];
   assign comparator_demux_control_o     = r_word[3];
   assign passthrough_demux_control_o    = r_word[2];
   assign output_demux_control_o         = r_word[1:0];
   assign busy_o                         = (r_state == ST_ISSUE);
   assign done_o                         = (r_state == ST_ISSUE) && w_last;
   assign illegal_o                      = r_illegal;
   assign remaining_o                    = r_rem;

endmodule
`default_nettype wire

// File: tb/tb_opcode_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_opcode_sequencer
//  Description : Self-checking bench for opcode_sequencer: directed scenarios
//                with literal expectations plus randomized traffic compared
//                every cycle against a cycles-left behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_opcode_sequencer;

   localparam int CNT_W = 10;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             op_valid = 1'b0;
   logic             op_ready;
   logic [3:0]       op = 4'h0;
   logic [CNT_W-1:0] arg = '0;
   logic             abort = 1'b0;
   logic [2:0]       prim;
   logic [1:0]       sec;
   logic [1:0]       bc;
   logic             cr;
   logic             cd;
   logic             pd;
   logic [1:0]       od;
   logic             busy;
   logic             done;
   logic             illegal;
   logic [CNT_W-1:0] rem;

   int checks = 0;
   int failures = 0;

   // Model: number of issue cycles left including the current one (0 = idle).
   int          m_left = 0;
   logic [11:0] m_word = 12'h000;
   logic        m_ill  = 1'b0;
   logic        chk_en = 1'b0;

   opcode_sequencer #(.CNT_W(CNT_W)) dut (
      .clk_i                          (clk),
      .rst_i                          (rst),
      .op_valid_i                     (op_valid),
      .op_ready_o                     (op_ready),
      .op_i                           (op),
      .arg_i                          (arg),
      .abort_i                        (abort),
      .primary_register_control_o     (prim),
      .secondary_register_control_o   (sec),
      .bit_counter_register_control_o (bc),
      .comparator_register_control_o  (cr),
      .comparator_demux_control_o     (cd),
      .passthrough_demux_control_o    (pd),
      .output_demux_control_o         (od),
      .busy_o                         (busy),
      .done_o                         (done),
      .illegal_o                      (illegal),
      .remaining_o                    (rem)
   );

   always #5 clk = ~clk;

   function automatic logic [11:0] spec_word(input logic [3:0] o);
      case (o)
         4'h0: return 12'hE00;
         4'h1: return 12'hC00;
         4'h2: return 12'h600;
         4'h3: return 12'h220;
         4'h4: return 12'h180;
         4'h5: return 12'h100;
         4'h6: return 12'h080;
         4'h7: return 12'h002;
         4'h8: return 12'h003;
         4'h9: return 12'h040;
         4'hA: return 12'h010;
         4'hB: return 12'h001;
         4'hC: return 12'h005;
         default: return 12'h000;
      endcase
   endfunction

   function automatic logic [11:0] dut_word();
      return {prim, sec, bc, cr, cd, pd, od};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Model update at each rising edge using the inputs presented there.
   always @(posedge clk) begin
      if (rst) begin
         m_left <= 0;
         m_word <= 12'h000;
         m_ill  <= 1'b0;
         chk_en <= 1'b1;
      end else if (abort) begin
         m_left <= 0;
      end else if (op_valid && m_left <= 1) begin
         if (op == 4'h2 || op == 4'h3 || op == 4'h6)
            m_left <= (arg == '0) ? 1 : int'(arg);
         else
            m_left <= 1;
         m_word <= spec_word(op);
         m_ill  <= (op == 4'hD || op == 4'hE);
      end else if (m_left > 0) begin
         m_left <= m_left - 1;
      end
   end

   // Per-cycle comparison of every output against the model, mid-cycle.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("ready", 32'(op_ready), 32'(!rst && !abort && m_left <= 1));
         chk("busy", 32'(busy), 32'(m_left > 0));
         chk("done", 32'(done), 32'(m_left == 1));
         chk("illegal", 32'(illegal), 32'(m_left > 0 && m_ill));
         chk("remaining", 32'(rem), (m_left > 0) ? 32'(m_left - 1) : 32'd0);
         chk("word", 32'(dut_word()), (m_left > 0) ? 32'(m_word) : 32'd0);
      end
   end

   initial begin
      // Reset held three cycles, then a single-cycle opcode 0.
      repeat (3) tick();
      @(negedge clk);
      chk("lit_rst_busy", 32'(busy), 32'd0);
      chk("lit_rst_word", 32'(dut_word()), 32'd0);
      chk("lit_rst_ready", 32'(op_ready), 32'd0);
      chk("lit_rst_rem", 32'(rem), 32'd0);
      tick();
      rst = 1'b0; op_valid = 1'b1; op = 4'h0;
      tick();
      op_valid = 1'b0;
      @(negedge clk);
      chk("lit_op0_prim", 32'(prim), 32'd7);
      chk("lit_op0_done", 32'(done), 32'd1);
      tick();
      @(negedge clk);
      chk("lit_op0_after_busy", 32'(busy), 32'd0);
      chk("lit_op0_after_word", 32'(dut_word()), 32'd0);

      // Opcode 3 repeated five times.
      tick();
      op_valid = 1'b1; op = 4'h3; arg = CNT_W'(5);
      tick();
      op_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("lit_rep_word", 32'(dut_word()), 32'h220);
         chk("lit_rep_rem", 32'(rem), 32'(4 - i));
         chk("lit_rep_done", 32'(done), 32'(i == 4));
         tick();
      end
      @(negedge clk);
      chk("lit_rep_end_busy", 32'(busy), 32'd0);

      // Back-to-back: opcode 2 x2 then opcode 8 with valid held.
      tick();
      op_valid = 1'b1; op = 4'h2; arg = CNT_W'(2);
      tick();
      op = 4'h8;
      @(negedge clk);
      chk("lit_b2b_w0", 32'(dut_word()), 32'h600);
      chk("lit_b2b_ready0", 32'(op_ready), 32'd0);
      tick();
      @(negedge clk);
      chk("lit_b2b_w1", 32'(dut_word()), 32'h600);
      tick();
      op_valid = 1'b0;
      @(negedge clk);
      chk("lit_b2b_w2", 32'(dut_word()), 32'h003);
      tick();

      // Abort on the third issue cycle of opcode 6 x10.
      op_valid = 1'b1; op = 4'h6; arg = CNT_W'(10);
      tick();
      op_valid = 1'b0;
      tick();
      tick();
      abort = 1'b1; op_valid = 1'b1; op = 4'h0;
      @(negedge clk);
      chk("lit_abort_word", 32'(dut_word()), 32'h080);
      chk("lit_abort_ready", 32'(op_ready), 32'd0);
      tick();
      abort = 1'b0; op_valid = 1'b0;
      @(negedge clk);
      chk("lit_abort_busy", 32'(busy), 32'd0);
      chk("lit_abort_done", 32'(done), 32'd0);
      chk("lit_abort_rem", 32'(rem), 32'd0);
      tick();

      // Illegal, NOP, then opcode 3 with argument 0.
      op_valid = 1'b1; op = 4'hD; arg = '0;
      tick();
      op = 4'hF;
      @(negedge clk);
      chk("lit_ill_illegal", 32'(illegal), 32'd1);
      chk("lit_ill_done", 32'(done), 32'd1);
      chk("lit_ill_word", 32'(dut_word()), 32'd0);
      tick();
      op = 4'h3;
      @(negedge clk);
      chk("lit_nop_illegal", 32'(illegal), 32'd0);
      chk("lit_nop_busy", 32'(busy), 32'd1);
      tick();
      op_valid = 1'b0;
      @(negedge clk);
      chk("lit_arg0_word", 32'(dut_word()), 32'h220);
      chk("lit_arg0_done", 32'(done), 32'd1);
      tick();

      // Reset in the middle of a repeat.
      op_valid = 1'b1; op = 4'h3; arg = CNT_W'(8);
      tick();
      op_valid = 1'b0;
      repeat (3) tick();
      rst = 1'b1;
      tick();
      @(negedge clk);
      chk("lit_mrst_busy", 32'(busy), 32'd0);
      chk("lit_mrst_word", 32'(dut_word()), 32'd0);
      chk("lit_mrst_ready", 32'(op_ready), 32'd0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("lit_mrst_ready_back", 32'(op_ready), 32'd1);
      tick();

      // Maximum argument: 2^CNT_W-1 issue cycles.
      op_valid = 1'b1; op = 4'h6; arg = '1;
      tick();
      op_valid = 1'b0;
      @(negedge clk);
      chk("lit_max_rem_first", 32'(rem), 32'd1022);
      repeat (1022) tick();
      @(negedge clk);
      chk("lit_max_rem_last", 32'(rem), 32'd0);
      chk("lit_max_done", 32'(done), 32'd1);
      tick();
      @(negedge clk);
      chk("lit_max_end_busy", 32'(busy), 32'd0);
      tick();

      // Randomized traffic.
      for (int n = 0; n < 4000; n++) begin
         rst      = ($urandom_range(0, 199) == 0);
         abort    = ($urandom_range(0, 24) == 0);
         op_valid = ($urandom_range(0, 2) != 0);
         op       = 4'($urandom_range(0, 15));
         arg      = ($urandom_range(0, 9) == 0) ? CNT_W'($urandom_range(0, 60))
                                                : CNT_W'($urandom_range(0, 6));
         tick();
      end
      rst = 1'b0; abort = 1'b0; op_valid = 1'b0;
      repeat (3) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/opcode_sequencer.md
OPCODE_SEQUENCER -- requirements
Module: opcode_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 10: width of repeat count argument.
REQ-002 SHALL have port clk_i, input, 1: sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_i, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port op_valid_i, input, 1: opcode offered.
REQ-005 SHALL have port op_ready_o, output, 1: opcode accepted when op_valid_i and op_ready_o are both high at a rising edge.
REQ-006 SHALL have port op_i, input, 4: opcode.
REQ-007 SHALL have port arg_i, input, CNT_W: repeat count N for repeatable opcodes.
REQ-008 SHALL have port abort_i, input, 1: terminate current operation.
REQ-009 SHALL have port primary_register_control_o, output, 3: control word bits [11:9].
REQ-010 SHALL have port secondary_register_control_o, output, 2: control word bits [8:7].
REQ-011 SHALL have port bit_counter_register_control_o, output, 2: control word bits [6:5].
REQ-012 SHALL have port comparator_register_control_o, output, 1: control word bit [4].
REQ-013 SHALL have port comparator_demux_control_o, output, 1: control word bit [3].
REQ-014 SHALL have port passthrough_demux_control_o, output, 1: control word bit [2].
REQ-015 SHALL have port output_demux_control_o, output, 2: control word bits [1:0].
REQ-016 SHALL have port busy_o, output, 1: an operation is issuing this cycle.
REQ-017 SHALL have port done_o, output, 1: pulse on last issue cycle of each accepted operation.
REQ-018 SHALL have port illegal_o, output, 1: pulse on the issue cycle of an illegal opcode.
REQ-019 SHALL have port remaining_o, output, CNT_W: issue cycles left after the current one.

Function
REQ-020 SHALL drive all control outputs from a registered 12-bit control word.
REQ-021 The control word SHALL be 0x000 (hold-all) whenever busy_o is low.
REQ-022 Opcode-to-word map SHALL be: 0:0xE00, 1:0xC00, 2:0x600, 3:0x220, 4:0x180, 5:0x100, 6:0x080, 7:0x002 (XOR), 8:0x003, 9:0x040, A:0x010, B:0x001, C:0x005, F:0x000 (NOP), D/E:0x000 (illegal).
REQ-023 Opcodes 2, 3, 6 SHALL be repeatable: issue the word for N consecutive cycles, with arg_i==0 treated as N=1.
REQ-024 All other opcodes SHALL ignore arg_i and issue exactly one cycle.
REQ-025 Latency SHALL be one cycle: the first issue cycle is the cycle after acceptance.
REQ-026 FSM SHALL have states IDLE and ISSUE.
REQ-027 FSM transitions: IDLE->ISSUE on accept; ISSUE->ISSUE on accept during last cycle or while remaining_o>0; ISSUE->IDLE on last cycle without accept, or on abort.
REQ-028 op_ready_o SHALL equal !rst_i && !abort_i && (state==IDLE || remaining_o==0), giving zero-bubble back-to-back issue.
REQ-029 remaining_o SHALL load N-1 on accept and decrement by 1 each ISSUE cycle, never wrapping below 0.
REQ-030 busy_o SHALL be high exactly in ISSUE state.
REQ-031 done_o SHALL be high when in ISSUE and remaining_o==0.
REQ-032 illegal_o SHALL be high on the single issue cycle of opcode D or E; done_o is also high on that cycle.
REQ-033 When abort_i is high at an edge, the next cycle SHALL be IDLE with word 0x000 and remaining_o=0, and no opcode is accepted at that edge.
REQ-034 An aborted operation SHALL NOT pulse done_o after the abort.
REQ-035 arg_i of maximum value SHALL give 2^CNT_W-1 issue cycles without overflow.

Reset
REQ-036 While rst_i is high at an edge, the next state SHALL be IDLE and every output SHALL be 0, including op_ready_o, remaining_o and all control fields.
REQ-037 Reset SHALL override abort_i and any in-progress or concurrently offered opcode.
REQ-038 op_ready_o SHALL rise in the first cycle after rst_i deasserts.

Verification
REQ-039 Scenario: reset held 3 cycles, then op 0x0 accepted -> one cycle of primary=3'b111 with done_o=1, then 0x000 and busy_o=0.
REQ-040 Scenario: op 0x3, arg 5 -> 5 cycles of word 0x220, remaining_o 4..0, done_o only on the fifth cycle.
REQ-041 Scenario: op 0x2 arg 2 followed by op 0x8 with op_valid_i held -> words 0x600, 0x600, 0x003 on consecutive cycles with no gap, and op_ready_o low on the first 0x600 cycle.
REQ-042 Scenario: op 0x6 arg 10 with abort_i pulsed on the third issue cycle -> 3 cycles of 0x080, then 0x000, IDLE, no done_o, and op_valid_i offered with the abort is not accepted.
REQ-043 Scenario: ops 0xD, 0xF, 0x3 with arg 0 -> illegal_o+done_o with 0x000; done_o with 0x000; one cycle of 0x220.
REQ-044 Scenario: rst_i asserted mid-repeat (op 0x3, arg 8, cycle 4) -> next cycle all outputs 0; op_ready_o returns to 1 one cycle after release.
